aes_rkey_store: RTL

//  Sequencer and store downstream of the 128-bit AES key expander. Drives the expander's
//  kld/enable pins, captures all 11 round keys (rk0..rk10) into local flops, then replays

---
 rtl/aes_rkey_store_pkg.sv | 19 +
 rtl/aes_rkey_store_regfile.sv | 42 ++++
 rtl/aes_rkey_store.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes_rkey_store_pkg.sv
// Shared definitions for the AES-128 round-key store.
// Holds the round count, the stored-key width and the sequencer state encoding
// so the store, its register file and any neighbouring block agree on them.
package aes_rkey_store_pkg;

    localparam int AES_NR   = 10;          // rounds for a 128-bit key
    localparam int AES_NRK  = AES_NR + 1;  // round keys kept: rk0..rk10
    localparam int AES_IDXW = 4;           // round index width, 2**IDXW > NR
    localparam int AES_RK_W = 128;         // one round key = four 32-bit words

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_READY  = 3'd3,
        ST_STREAM = 3'd4
    } rks_state_t;

endpackage

// File: rtl/aes_rkey_store_regfile.sv
// Register file holding the NR+1 round keys.
// Ports:
//   clk, rst_n  clock and asynchronous active-low clear of every entry
//   wr_en       write strobe, wr_data lands in entry wr_idx at the clock edge
//   wr_idx      entry to write (0..NR)
//   wr_data     128-bit round key to store
//   rd_idx      entry to read, combinational
//   rd_data     contents of entry rd_idx, 0 for an index beyond NR
module aes_rkey_store_regfile
    import aes_rkey_store_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int IDXW = AES_IDXW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDXW-1:0]     wr_idx,
    input  logic [AES_RK_W-1:0] wr_data,
    input  logic [IDXW-1:0]     rd_idx,
    output logic [AES_RK_W-1:0] rd_data
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

    logic [AES_RK_W-1:0] mem [NR+1];

    // Storage is lost on reset so a stale key can never be replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx <= LAST_IDX)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Indices 11..15 are unreachable in normal operation; read them as zero.
    assign rd_data = (rd_idx <= LAST_IDX) ? mem[rd_idx] : '0;

endmodule

// File: rtl/aes_rkey_store.sv
// AES-128 round-key sequencer and store.
// Drives the key expander, captures rk0..rk10 and replays them to the cipher
// datapath over a valid/ready stream, forward for encrypt or reverse for decrypt.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_ld, key           start strobe and cipher key (byte 0 in bits [127:120])
//   ex_key                registered key presented to the expander
//   ex_kld, ex_enable     expander load and advance strobes
//   ex_rkey0..ex_rkey3    expander round-key words w[0]..w[3]
//   key_ready             all round keys are stored
//   rd_start, rd_dir      stream start strobe and direction (1 = rk10 first)
//   rk_valid, rk_ready    stream handshake
//   rk_out, rk_idx        round key {w0,w1,w2,w3} and its index
//   rk_last               final beat of the stream
module aes_rkey_store
    import aes_rkey_store_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int IDXW = AES_IDXW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_ld,
    input  logic [AES_RK_W-1:0] key,
    output logic [AES_RK_W-1:0] ex_key,
    output logic                ex_kld,
    output logic                ex_enable,
    input  logic [31:0]         ex_rkey0,
    input  logic [31:0]         ex_rkey1,
    input  logic [31:0]         ex_rkey2,
    input  logic [31:0]         ex_rkey3,
    output logic                key_ready,
    input  logic                rd_start,
    input  logic                rd_dir,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [AES_RK_W-1:0] rk_out,
    output logic [IDXW-1:0]     rk_idx,
    output logic                rk_last
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

    rks_state_t          state, state_n;
    logic [AES_RK_W-1:0] key_r, key_r_n;
    logic                key_ready_n;
    logic [IDXW-1:0]     cnt, cnt_n;
    logic [IDXW-1:0]     idx, idx_n;
    logic                dir_r, dir_n;
    logic [AES_RK_W-1:0] rd_data;
    logic                streaming;
    logic                last_beat;

    aes_rkey_store_regfile #(
        .NR   (NR),
        .IDXW (IDXW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (state == ST_EXPAND),
        .wr_idx  (cnt),
        .wr_data ({ex_rkey0, ex_rkey1, ex_rkey2, ex_rkey3}),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    assign streaming = (state == ST_STREAM);
    // The end index depends on the direction latched at stream start.
    assign last_beat = dir_r ? (idx == '0) : (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_r     <= '0;
            key_ready <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            dir_r     <= 1'b0;
        end else begin
            state     <= state_n;
            key_r     <= key_r_n;
            key_ready <= key_ready_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            dir_r     <= dir_n;
        end
    end

    // key_ld is checked before the state case so a new key always wins,
    // aborting an expansion or stream and beating a simultaneous rd_start.
    // EXPAND samples the expander one cycle after each load/advance strobe,
    // so the capture of entry cnt always sees round key cnt.
    always_comb begin
        state_n     = state;
        key_r_n     = key_r;
        key_ready_n = key_ready;
        cnt_n       = cnt;
        idx_n       = idx;
        dir_n       = dir_r;
        if (key_ld) begin
            key_r_n     = key;
            key_ready_n = 1'b0;
            state_n     = ST_LOAD;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    cnt_n   = '0;
                    state_n = ST_EXPAND;
                end
                ST_EXPAND: begin
                    if (cnt == LAST_IDX) begin
                        key_ready_n = 1'b1;
                        state_n     = ST_READY;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (rd_start) begin
                        dir_n   = rd_dir;
                        idx_n   = rd_dir ? LAST_IDX : '0;
                        state_n = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rk_ready) begin
                        if (last_beat) begin
                            state_n = ST_READY;
                        end else begin
                            idx_n = dir_r ? (idx - 1'b1) : (idx + 1'b1);
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Stream outputs are forced to zero outside STREAM so the datapath never
    // sees stale keys; the load and advance strobes come from exclusive states.
    always_comb begin
        ex_key    = key_r;
        ex_kld    = (state == ST_LOAD);
        ex_enable = (state == ST_EXPAND) && (cnt < LAST_IDX);
        rk_valid  = streaming;
        rk_out    = streaming ? rd_data : '0;
        rk_idx    = streaming ? idx : '0;
        rk_last   = streaming && last_beat;
    end

endmodule
